// File: rtl/conv3x3_engine.sv
// conv3x3_engine: sequential 3x3 convolution responder for the image-filter datapath.
// Latency: start_conv sampled at E0 -> done_conv/result_valid high in the cycle after E10 (11 cycles).
// Backpressure: none; start_conv is a held level request, shift_en/coef writes are ignored while busy.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   shift_en, pixel_in[7:0]    window shift strobe and unsigned pixel (IDLE only)
//   start_conv                 level request, held until done_conv is seen
//   coef_we, coef_addr[3:0],   kernel write port, index 0..8 row-major, signed data
//   coef_data[7:0]
//   done_conv, result_valid    one-cycle completion / result-memory write strobe
//   busy                       high in every state other than IDLE
//   result_data[7:0]           normalised output pixel
//   result_addr[13:0]          raster address of the output pixel
//
// Parameters: NORM_SHIFT (arithmetic right shift of the sum), PIXELS (address wrap point).
// Optional feature: define CONV3X3_SAT_EN to clamp the normalised sum to [0,255];
// otherwise the low 8 bits of the normalised sum are output (wrap-around).

module conv3x3_engine #(
    parameter int NORM_SHIFT = 0,
    parameter int PIXELS     = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic [7:0]  pixel_in,
    input  logic        start_conv,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic        done_conv,
    output logic        busy,
    output logic        result_valid,
    output logic [7:0]  result_data,
    output logic [13:0] result_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_NORM,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    localparam logic [13:0] LAST_ADDR = 14'(PIXELS - 1);

    state_t             state_q;
    logic [7:0]         win_q  [9];
    logic signed [7:0]  coef_q [9];
    logic signed [19:0] acc_q;
    logic [3:0]         k_q;
    logic [13:0]        cnt_q;

    logic               done_q;
    logic               valid_q;
    logic               busy_q;
    logic [7:0]         data_q;
    logic [13:0]        addr_q;

    // Tap selection and product for the current k.
    logic [7:0]         tap_pix;
    logic signed [7:0]  tap_coef;
    logic signed [16:0] pix_ext;
    logic signed [16:0] coef_ext;
    logic signed [16:0] prod;
    logic signed [19:0] acc_d;
    logic [7:0]         norm_pix;
    logic [13:0]        cnt_d;
`ifdef CONV3X3_SAT_EN
    logic signed [19:0] norm_r;
`endif

    always_comb begin
        tap_pix  = '0;
        tap_coef = '0;
        for (int i = 0; i < 9; i++) begin
            if (k_q == 4'(i)) begin
                tap_pix  = win_q[i];
                tap_coef = coef_q[i];
            end
        end
        // Pixel is unsigned: zero-extend; coefficient is signed: sign-extend.
        pix_ext  = {9'b0, tap_pix};
        coef_ext = {{9{tap_coef[7]}}, tap_coef};
        prod     = pix_ext * coef_ext;
        acc_d    = acc_q + {{3{prod[16]}}, prod};
    end

    always_comb begin
`ifdef CONV3X3_SAT_EN
        norm_r = acc_q >>> NORM_SHIFT;
        if (norm_r < 0) begin
            norm_pix = 8'd0;
        end else if (norm_r > 20'sd255) begin
            norm_pix = 8'hFF;
        end else begin
            norm_pix = norm_r[7:0];
        end
`else
        norm_pix = 8'(acc_q >>> NORM_SHIFT);
`endif
    end

    always_comb begin
        cnt_d = (cnt_q == LAST_ADDR) ? 14'd0 : cnt_q + 14'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 9; i++) begin
                win_q[i]  <= '0;
                coef_q[i] <= (i == 4) ? 8'sd1 : 8'sd0;
            end
            acc_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A shift coinciding with start is still taken; MAC reads the
                    // window from the next cycle, so it sees the post-shift data.
                    if (shift_en) begin
                        for (int i = 0; i < 8; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[8] <= pixel_in;
                    end
                    if (coef_we) begin
                        for (int i = 0; i < 9; i++) begin
                            if (coef_addr == 4'(i)) begin
                                coef_q[i] <= coef_data;
                            end
                        end
                    end
                    if (start_conv) begin
                        acc_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == 4'd8) begin
                        state_q <= S_NORM;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                S_NORM: begin
                    data_q  <= norm_pix;
                    addr_q  <= cnt_q;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // The address has already been presented; advance for the next pixel.
                    cnt_q   <= cnt_d;
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // Wait for the request to drop so one request yields one result.
                    if (!start_conv) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done_conv    = done_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign result_data  = data_q;
    assign result_addr  = addr_q;

endmodule
